// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//  - MD_* : op encodings presented on op[2:0]
//  - IDLE/RUN/FIX : sequencer states
//  - ITER : shift/add or restoring-divide iterations per operation
package muldiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int ITER     = MD_WIDTH;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t FIX  = 2'd2;

    // mult and div work on magnitudes and fix the signs up afterwards
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> muldiv unit bundle.
//  master (EX side) drives : start, op, rs_val, rt_val, flush, rd_req, rd_sel
//  slave  (unit)    drives : rd_data, hi, lo, busy, stall, done
interface muldiv_if #(parameter int WIDTH = 32);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             rd_req;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start, op, rs_val, rt_val, flush, rd_req, rd_sel,
        input  rd_data, hi, lo, busy, stall, done
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush, rd_req, rd_sel,
        output rd_data, hi, lo, busy, stall, done
    );

endinterface

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath for unsigned multiply and restoring divide.
//  clk, reset : clock, asynchronous active-low reset
//  load       : capture a_in/b_in, clear accumulator and counter
//  step       : perform one iteration and advance the counter
//  is_div     : 1 = divide step, 0 = shift-add multiply step
//  a_in, b_in : multiplier/dividend and multiplicand/divisor magnitudes
//  acc_hi     : product upper half / remainder
//  acc_lo     : product lower half / quotient
//  last       : the current step is the final iteration
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_hi_reg, acc_hi_next;
    logic [WIDTH-1:0] acc_lo_reg, acc_lo_next;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then
        // shift {carry, acc_hi, acc_lo} right; acc_lo drains the multiplier.
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, b_reg} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // trial-subtract; the extra top bit of div_diff is the borrow.
        div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_reg};
        if (is_div) begin
            if (!div_diff[WIDTH+1]) begin
                acc_hi_next = div_diff[WIDTH-1:0];
                acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_next = div_shift[WIDTH-1:0];
                acc_lo_next = {acc_lo_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_next = mul_sum[WIDTH:1];
            acc_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            acc_hi_reg <= '0;
            acc_lo_reg <= a_in;
            b_reg      <= b_in;
            cnt_reg    <= '0;
        end else if (step) begin
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            cnt_reg    <= cnt_reg + CW'(1);
        end
    end

    assign acc_hi = acc_hi_reg;
    assign acc_lo = acc_lo_reg;
    assign last   = (cnt_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide sequencer owning architectural HI/LO.
//  clk   : clock, rising edge
//  reset : asynchronous active-low reset
//  bus   : muldiv_if slave (start/op/rs_val/rt_val/flush/rd_req/rd_sel in;
//          rd_data/hi/lo/busy/stall/done out)
// Holds the IDLE/RUN/FIX FSM, sign capture, result fixup, HI/LO and stall.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_t           state_reg;
    logic             is_div_reg, div0_reg, neg_res_reg, neg_rem_reg, done_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    logic             accept, op_arith, op_div, op_signed, div_zero, load, step, last;
    logic [WIDTH-1:0] rs_abs, rt_abs, a_load;
    logic [WIDTH-1:0] acc_hi, acc_lo, quo_fix, rem_fix, hi_fix, lo_fix;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign accept    = bus.start && !bus.flush && (state_reg == IDLE);
    assign op_arith  = !bus.op[2];
    assign op_div    = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
    assign op_signed = is_signed_op(bus.op);
    assign div_zero  = op_div && (bus.rt_val == '0);

    assign rs_abs = (op_signed && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    assign rt_abs = (op_signed && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
    // Divide-by-zero parks the raw dividend in acc_lo so FIX can copy it to HI.
    assign a_load = div_zero ? bus.rs_val : rs_abs;

    assign load = accept && op_arith;
    assign step = (state_reg == RUN);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (is_div_reg),
        .a_in   (a_load),
        .b_in   (rt_abs),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .last   (last)
    );

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res_reg ? -prod : prod;
        quo_fix  = neg_res_reg ? -acc_lo : acc_lo;
        rem_fix  = neg_rem_reg ? -acc_hi : acc_hi;
        if (div0_reg) begin
            hi_fix = acc_lo;
            lo_fix = '1;
        end else if (is_div_reg) begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            hi_reg      <= '0;
            lo_reg      <= '0;
            is_div_reg  <= 1'b0;
            div0_reg    <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (bus.op == MD_MTHI) begin
                            hi_reg <= bus.rs_val;
                        end else if (bus.op == MD_MTLO) begin
                            lo_reg <= bus.rs_val;
                        end else if (op_arith) begin
                            state_reg   <= div_zero ? FIX : RUN;
                            is_div_reg  <= op_div;
                            div0_reg    <= div_zero;
                            neg_res_reg <= op_signed && (bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1]);
                            neg_rem_reg <= op_signed && bus.rs_val[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    if (last) state_reg <= FIX;
                end
                FIX: begin
                    hi_reg    <= hi_fix;
                    lo_reg    <= lo_fix;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state_reg != IDLE);
    assign bus.stall   = bus.busy && (bus.rd_req || bus.start);
    assign bus.done    = done_reg;
    assign bus.hi      = hi_reg;
    assign bus.lo      = lo_reg;
    assign bus.rd_data = bus.rd_sel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: mul/div vectors, divide-by-zero, stall
// behaviour, async reset, flush, mthi/mtlo.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_if #(.WIDTH(32)) bus();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then wait (bounded) for done. lat counts the cycle index
    // after the accept edge (1 = first cycle after accept).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int nbusy);
        bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
        tick();
        bus.start = 1'b0;
        lat = 1; nbusy = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) nbusy++;
            tick();
            lat++;
        end
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs [9] = '{
        '{MD_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd34},
        '{MD_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 8'd34},
        '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 8'd34},
        '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 8'd34},
        '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 8'd34},
        '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 8'd2},
        '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 8'd34},
        '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 8'd34},
        '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 8'd2}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nbusy, cyc, stall_bad;

        reset = 1'b0;
        bus.start = 1'b1; bus.op = MD_MULT; bus.rs_val = 32'h3; bus.rt_val = 32'h3;
        bus.flush = 1'b0; bus.rd_req = 1'b1; bus.rd_sel = 1'b1;
        tick(); tick();
        check("rst_hi",    bus.hi,    32'h0);
        check("rst_lo",    bus.lo,    32'h0);
        check("rst_busy",  bus.busy,  32'h0);
        check("rst_done",  bus.done,  32'h0);
        check("rst_stall", bus.stall, 32'h0);
        bus.start = 1'b0; bus.rd_req = 1'b0;
        reset = 1'b1;
        tick();

        // Directed arithmetic vectors
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nbusy);
            $display("txn %0d op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d busy=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, bus.hi, bus.lo, lat, nbusy);
            check($sformatf("v%0d_done", i),  bus.done, 32'h1);
            check($sformatf("v%0d_lat", i),   lat,      32'(vecs[i].lat));
            check($sformatf("v%0d_nbusy", i), nbusy,    32'(vecs[i].lat) - 32'd1);
            check($sformatf("v%0d_busy", i),  bus.busy, 32'h0);
            check($sformatf("v%0d_hi", i),    bus.hi,   vecs[i].hi);
            check($sformatf("v%0d_lo", i),    bus.lo,   vecs[i].lo);
            bus.rd_sel = 1'b0;
            #1;
            check($sformatf("v%0d_rd_lo", i), bus.rd_data, vecs[i].lo);
            tick();
            check($sformatf("v%0d_pulse", i), bus.done, 32'h0);
        end

        // mfhi held through a multiply, with a second start held during busy
        bus.start = 1'b1; bus.op = MD_MULTU; bus.rs_val = 32'hFFFFFFFF; bus.rt_val = 32'hFFFFFFFF;
        tick();
        bus.op = MD_MTLO; bus.rs_val = 32'h0000AAAA; bus.rd_req = 1'b1; bus.rd_sel = 1'b1;
        #1;
        cyc = 1; stall_bad = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.stall !== 1'b1) stall_bad++;
            tick();
            cyc++;
        end
        $display("txn mfhi-during-mult cyc=%0d rd_data=%08h stall=%0d", cyc, bus.rd_data, bus.stall);
        check("t4_stall_busy", stall_bad,   32'h0);
        check("t4_lat",        cyc,         32'd34);
        check("t4_stall_done", bus.stall,   32'h0);
        check("t4_rd_data",    bus.rd_data, 32'hFFFFFFFE);
        tick();
        bus.start = 1'b0; bus.rd_req = 1'b0;
        $display("txn held-mtlo hi=%08h lo=%08h", bus.hi, bus.lo);
        check("t4_lo_mtlo", bus.lo,   32'h0000AAAA);
        check("t4_hi",      bus.hi,   32'hFFFFFFFE);
        check("t4_busy",    bus.busy, 32'h0);

        // mthi / mtlo on consecutive edges
        bus.start = 1'b1; bus.op = MD_MTHI; bus.rs_val = 32'h1234;
        tick();
        check("t6_busy1", bus.busy, 32'h0);
        bus.op = MD_MTLO; bus.rs_val = 32'h5678;
        tick();
        bus.start = 1'b0;
        $display("txn mthi/mtlo hi=%08h lo=%08h", bus.hi, bus.lo);
        check("t6_busy2", bus.busy, 32'h0);
        check("t6_hi",    bus.hi,   32'h1234);
        check("t6_lo",    bus.lo,   32'h5678);
        bus.rd_req = 1'b1; bus.rd_sel = 1'b1;
        #1;
        check("t6_mfhi_stall", bus.stall,   32'h0);
        check("t6_mfhi",       bus.rd_data, 32'h1234);
        // mthi in the same cycle as mfhi: read sees the old HI
        bus.start = 1'b1; bus.op = MD_MTHI; bus.rs_val = 32'hBEEF;
        #1;
        check("t6_same_old", bus.rd_data, 32'h1234);
        tick();
        bus.start = 1'b0;
        $display("txn mthi+mfhi rd_data=%08h", bus.rd_data);
        check("t6_new_hi", bus.rd_data, 32'hBEEF);
        bus.rd_sel = 1'b0;
        #1;
        check("t6_mflo", bus.rd_data, 32'h5678);
        bus.rd_req = 1'b0;

        // Async reset in the middle of RUN
        bus.start = 1'b1; bus.op = MD_MULT; bus.rs_val = 32'h3; bus.rt_val = 32'h3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.rd_req = 1'b1;
        #1;
        check("t5_stall_pre", bus.stall, 32'h1);
        #1 reset = 1'b0;
        #1;
        $display("txn async-reset busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
        check("t5_busy",  bus.busy,  32'h0);
        check("t5_stall", bus.stall, 32'h0);
        check("t5_done",  bus.done,  32'h0);
        check("t5_hi",    bus.hi,    32'h0);
        check("t5_lo",    bus.lo,    32'h0);
        tick();
        reset = 1'b1; bus.rd_req = 1'b0;
        tick();

        // Flushed starts are ignored
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = MD_MTHI; bus.rs_val = 32'h99;
        tick();
        check("t5_flush_hi", bus.hi, 32'h0);
        bus.op = MD_MULT; bus.rs_val = 32'h3; bus.rt_val = 32'h3;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        $display("txn flushed-start busy=%0d hi=%08h", bus.busy, bus.hi);
        check("t5_flush_busy", bus.busy, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
